// File: rtl/lsu_if.sv
// Word-wide data-memory bus between the load/store unit (master) and data memory (slave).
// Handshake: m_req and all request fields stay stable until the cycle m_gnt=1; loads then get one m_rvalid beat.
interface lsu_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wstrb, m_wdata,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wstrb, m_wdata,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit: lane steering, load extension, misalign/illegal/timeout reporting.
// state_o exposes the FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE) for debug and checkers.
module lsu #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        fault_o,
    output logic [1:0]  state_o,
    lsu_if.master       mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               misalign_q, misalign_d;
    logic               fault_q, fault_d;

    logic               op_onehot;
    logic               in_misalign;
    logic               is_store;
    logic               timeout_hit;
    logic [1:0]         off;
    logic [31:0]        shifted;
    logic [31:0]        load_ext;
    logic [3:0]         strb;
    logic [31:0]        lane_wdata;

    // Zero is filtered out before this is consulted, so "no two bits set" means one-hot here.
    assign op_onehot   = (mem_op_i & (mem_op_i - 8'd1)) == 8'd0;
    assign in_misalign = ((mem_op_i[1] | mem_op_i[4] | mem_op_i[6]) & addr_i[0]) |
                         ((mem_op_i[2] | mem_op_i[7]) & (addr_i[1:0] != 2'b00));
    assign is_store    = |op_q[7:5];
    assign timeout_hit = cnt_q == CNT_W'(TIMEOUT - 1);
    assign off         = addr_q[1:0];
    assign shifted     = mem.m_rdata >> {off, 3'b000};

    always_comb begin
        load_ext = 32'd0;
        if (op_q[0])      load_ext = {{24{shifted[7]}}, shifted[7:0]};
        else if (op_q[3]) load_ext = {24'd0, shifted[7:0]};
        else if (op_q[1]) load_ext = {{16{shifted[15]}}, shifted[15:0]};
        else if (op_q[4]) load_ext = {16'd0, shifted[15:0]};
        else if (op_q[2]) load_ext = shifted;
    end

    always_comb begin
        strb       = 4'b0000;
        lane_wdata = 32'd0;
        if (op_q[5]) begin
            strb       = 4'b0001 << off;
            lane_wdata = {4{wdata_q[7:0]}};
        end else if (op_q[6]) begin
            strb       = 4'b0011 << off;
            lane_wdata = {2{wdata_q[15:0]}};
        end else if (op_q[7]) begin
            strb       = 4'b1111;
            lane_wdata = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (mem_op_i != 8'd0)) begin
                    op_d       = mem_op_i;
                    addr_d     = addr_i;
                    wdata_d    = wdata_i;
                    cnt_d      = '0;
                    misalign_d = 1'b0;
                    fault_d    = 1'b0;
                    if (!op_onehot) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else if (in_misalign) begin
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            // A grant or response in the timeout cycle still completes normally.
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.m_gnt) begin
                    state_d = is_store ? S_DONE : S_WAIT;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.m_rvalid) begin
                    rdata_d = load_ext;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o     = state_q != S_IDLE;
    assign done_o     = state_q == S_DONE;
    assign misalign_o = done_o & misalign_q;
    assign fault_o    = done_o & fault_q;
    assign rdata_o    = rdata_q;
    assign state_o    = state_q;

    assign mem.m_req   = state_q == S_REQ;
    assign mem.m_we    = mem.m_req & is_store;
    assign mem.m_addr  = mem.m_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem.m_wstrb = mem.m_req ? strb : 4'b0000;
    assign mem.m_wdata = mem.m_req ? lane_wdata : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table on a zero-wait bus plus stall, timeout and reset sequences.
module tb_lsu;

    localparam int TO = 8;
    localparam logic [1:0] K_ST = 2'd0, K_LD = 2'd1, K_MIS = 2'd2, K_ILL = 2'd3;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic [1:0]  kind;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_mwdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        fault_o;
    logic [1:0]  state_o;

    lsu_if mem();

    lsu #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .mem_op_i   (mem_op),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .misalign_o (misalign_o),
        .fault_o    (fault_o),
        .state_o    (state_o),
        .mem        (mem)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rdata = 32'd0;
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    vec_t        vecs[14];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // scoreboard: every done pulse must match the oldest expected {misalign, fault, rdata}
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    mon_e = exp_q.pop_front();
                    check1("done_misalign", misalign_o, mon_e[33]);
                    check1("done_fault", fault_o, mon_e[32]);
                    check32("done_rdata", rdata_o, mon_e[31:0]);
                end
            end else begin
                check32("flags_without_done", {30'd0, misalign_o, fault_o}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        start  = 1'b1;
        mem_op = op;
        addr   = a;
        wdata  = d;
    endtask

    task automatic drive_idle();
        start  = 1'b0;
        mem_op = 8'd0;
        addr   = 32'd0;
        wdata  = 32'd0;
    endtask

    task automatic run_vec(input vec_t v);
        if (v.kind == K_LD) model_rdata = v.exp_rdata;
        exp_q.push_back({v.kind == K_MIS, v.kind == K_ILL, model_rdata});
        drive_start(v.op, v.addr, v.wdata);
        tick();
        drive_idle();
        if (v.kind == K_MIS || v.kind == K_ILL) begin
            check1("err_done_latency", done_o, 1'b1);
            check1("err_no_req", mem.m_req, 1'b0);
        end else begin
            check1("req_asserted", mem.m_req, 1'b1);
            check32("req_addr", mem.m_addr, {v.addr[31:2], 2'b00});
            check32("req_wstrb", {28'd0, mem.m_wstrb}, {28'd0, v.exp_strb});
            check32("req_wdata", mem.m_wdata, v.exp_mwdata);
            check1("req_we", mem.m_we, v.kind == K_ST);
            mem.m_gnt = 1'b1;
            tick();
            mem.m_gnt = 1'b0;
            if (v.kind == K_ST) begin
                check1("store_done_latency", done_o, 1'b1);
            end else begin
                check1("wait_req_low", mem.m_req, 1'b0);
                check1("wait_no_done", done_o, 1'b0);
                mem.m_rvalid = 1'b1;
                mem.m_rdata  = v.mrdata;
                tick();
                mem.m_rvalid = 1'b0;
                mem.m_rdata  = 32'd0;
                check1("load_done_latency", done_o, 1'b1);
            end
        end
        check32("rdata_after_op", rdata_o, model_rdata);
        tick();
        check1("back_to_idle", busy_o, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{8'h80, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         K_ST,  32'h0,         4'b1111, 32'hDEAD_BEEF};
        vecs[1]  = '{8'h20, 32'h0000_0103, 32'h0000_00A5, 32'h0,         K_ST,  32'h0,         4'b1000, 32'hA5A5_A5A5};
        vecs[2]  = '{8'h40, 32'h0000_0102, 32'h1234_CAFE, 32'h0,         K_ST,  32'h0,         4'b1100, 32'hCAFE_CAFE};
        vecs[3]  = '{8'h01, 32'h0000_0202, 32'h0,         32'h1280_3456, K_LD,  32'hFFFF_FF80, 4'b0000, 32'h0};
        vecs[4]  = '{8'h08, 32'h0000_0202, 32'h0,         32'h1280_3456, K_LD,  32'h0000_0080, 4'b0000, 32'h0};
        vecs[5]  = '{8'h10, 32'h0000_0202, 32'h0,         32'h1280_3456, K_LD,  32'h0000_1280, 4'b0000, 32'h0};
        vecs[6]  = '{8'h02, 32'h0000_0202, 32'h0,         32'h8000_1234, K_LD,  32'hFFFF_8000, 4'b0000, 32'h0};
        vecs[7]  = '{8'h04, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, K_LD,  32'hCAFE_F00D, 4'b0000, 32'h0};
        vecs[8]  = '{8'h04, 32'h0000_0302, 32'h0,         32'h0,         K_MIS, 32'h0,         4'b0000, 32'h0};
        vecs[9]  = '{8'h40, 32'h0000_0101, 32'h0000_1111, 32'h0,         K_MIS, 32'h0,         4'b0000, 32'h0};
        vecs[10] = '{8'h03, 32'h0000_0200, 32'h0,         32'h0,         K_ILL, 32'h0,         4'b0000, 32'h0};
        vecs[11] = '{8'h01, 32'h0000_0201, 32'h0,         32'h0000_AB00, K_LD,  32'hFFFF_FFAB, 4'b0000, 32'h0};
        vecs[12] = '{8'h10, 32'h0000_0200, 32'h0,         32'hFFFF_7FFF, K_LD,  32'h0000_7FFF, 4'b0000, 32'h0};
        vecs[13] = '{8'h20, 32'h0000_0101, 32'h0000_003C, 32'h0,         K_ST,  32'h0,         4'b0010, 32'h3C3C_3C3C};

        rst          = 1'b1;
        drive_idle();
        mem.m_gnt    = 1'b0;
        mem.m_rvalid = 1'b0;
        mem.m_rdata  = 32'd0;
        repeat (2) tick();
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_done", done_o, 1'b0);
        check1("rst_req", mem.m_req, 1'b0);
        check1("rst_we", mem.m_we, 1'b0);
        check32("rst_maddr", mem.m_addr, 32'd0);
        check32("rst_wstrb", {28'd0, mem.m_wstrb}, 32'd0);
        check32("rst_mwdata", mem.m_wdata, 32'd0);
        check32("rst_rdata", rdata_o, 32'd0);
        check32("rst_state", {30'd0, state_o}, 32'd0);
        rst = 1'b0;
        tick();

        // start with a zero op is ignored
        drive_start(8'h00, 32'h100, 32'h1);
        tick();
        drive_idle();
        check1("zero_op_ignored", busy_o, 1'b0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // grant stalled three cycles: request fields must not move
        model_rdata = 32'h1122_3344;
        exp_q.push_back({1'b0, 1'b0, model_rdata});
        drive_start(8'h04, 32'h0000_0400, 32'hFFFF_FFFF);
        tick();
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            check1("stall_req", mem.m_req, 1'b1);
            check32("stall_addr", mem.m_addr, 32'h0000_0400);
            check32("stall_wstrb", {28'd0, mem.m_wstrb}, 32'd0);
            check1("stall_we", mem.m_we, 1'b0);
            if (i == 3) mem.m_gnt = 1'b1;
            tick();
        end
        mem.m_gnt = 1'b0;
        check1("stall_wait_req_low", mem.m_req, 1'b0);
        mem.m_rvalid = 1'b1;
        mem.m_rdata  = 32'h1122_3344;
        tick();
        mem.m_rvalid = 1'b0;
        check1("stall_done", done_o, 1'b1);
        tick();

        // timeout with a second start attempted while busy
        begin
            int req_cycles;
            logic seen;
            req_cycles = 0;
            seen = 1'b0;
            exp_q.push_back({1'b0, 1'b1, model_rdata});
            drive_start(8'h80, 32'h0000_0500, 32'h55);
            tick();
            drive_idle();
            for (int i = 0; i < 30; i++) begin
                if (done_o) begin
                    seen = 1'b1;
                    break;
                end
                if (mem.m_req) req_cycles++;
                start  = (i == 2);
                mem_op = (i == 2) ? 8'h01 : 8'h00;
                tick();
            end
            drive_idle();
            check1("timeout_done_seen", seen, 1'b1);
            check32("timeout_req_cycles", req_cycles, TO);
            check1("timeout_req_dropped", mem.m_req, 1'b0);
            tick();
            check1("timeout_idle", busy_o, 1'b0);
            check1("timeout_idle_req", mem.m_req, 1'b0);
        end

        // bus strobes while idle are ignored
        mem.m_gnt    = 1'b1;
        mem.m_rvalid = 1'b1;
        tick();
        mem.m_gnt    = 1'b0;
        mem.m_rvalid = 1'b0;
        check1("idle_strobe_ignored", busy_o, 1'b0);

        // reset while waiting for the load response, then a stray response
        drive_start(8'h04, 32'h0000_0600, 32'h0);
        tick();
        drive_idle();
        mem.m_gnt = 1'b1;
        tick();
        mem.m_gnt = 1'b0;
        check32("in_wait_state", {30'd0, state_o}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_rdata = 32'd0;
        check1("midrst_busy", busy_o, 1'b0);
        check1("midrst_req", mem.m_req, 1'b0);
        check1("midrst_done", done_o, 1'b0);
        check32("midrst_rdata", rdata_o, 32'd0);
        mem.m_rvalid = 1'b1;
        mem.m_rdata  = 32'hAAAA_5555;
        tick();
        mem.m_rvalid = 1'b0;
        repeat (3) begin
            check1("stray_rvalid_no_done", done_o, 1'b0);
            tick();
        end
        check32("stray_rvalid_rdata", rdata_o, 32'd0);

        run_vec(vecs[3]);

        repeat (2) tick();
        check32("scoreboard_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
